// File: rtl/fixed_mac_pkg.sv
// Shared types and helpers for the fixed-point MAC pipeline.
// Wide (128-bit) helpers are truncated to size by the users.
package fixed_mac_pkg;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_ACC = 1'b1
  } mode_e;

  localparam int XW = 128;

  // Largest positive value of a w-bit signed number.
  function automatic logic signed [XW-1:0] sat_max(input int w);
    logic signed [XW-1:0] one;
    one = 1;
    return (one <<< (w - 1)) - one;
  endfunction

  // Most negative value of a w-bit signed number.
  function automatic logic signed [XW-1:0] sat_min(input int w);
    logic signed [XW-1:0] one;
    one = 1;
    return -(one <<< (w - 1));
  endfunction

  // Drop frac fraction bits, optionally rounding half up first.
  function automatic logic signed [XW-1:0] shift_round(
    input logic signed [XW-1:0] p,
    input int                   frac,
    input logic                 rnd
  );
    logic signed [XW-1:0] t;
    logic signed [XW-1:0] one;
    one = 1;
    t   = p;
    if (rnd && frac > 0) t = t + (one <<< (frac - 1));
    return t >>> frac;
  endfunction

endpackage

// File: rtl/fixed_mac_pipe_sat_add.sv
// fixed_sat_add: widened signed add of accumulator and product,
// clamped to the ACC_WIDTH range, with a saturation flag.
module fixed_sat_add
  import fixed_mac_pkg::*;
#(
  parameter int ACC_WIDTH = 56,
  parameter int PW        = 56
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic signed [PW-1:0]        prod,
  output logic signed [ACC_WIDTH-1:0] res,
  output logic                        sat
);

  localparam int MW = (ACC_WIDTH > PW) ? ACC_WIDTH : PW;
  localparam int SW = MW + 1;

  localparam logic signed [SW-1:0] MAXV = SW'(sat_max(ACC_WIDTH));
  localparam logic signed [SW-1:0] MINV = SW'(sat_min(ACC_WIDTH));

  logic signed [SW-1:0] sum;

  // Add with one spare bit, then clamp anything outside ACC range.
  always_comb begin
    sum = SW'(acc) + SW'(prod);
    sat = 1'b0;
    res = sum[ACC_WIDTH-1:0];
    if (sum > MAXV) begin
      sat = 1'b1;
      res = MAXV[ACC_WIDTH-1:0];
    end else if (sum < MINV) begin
      sat = 1'b1;
      res = MINV[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fixed_mac_pipe.sv
// Pipelined signed fixed-point multiply / dot-product unit, 3 stages.
// Define FIXED_MAC_ROUND_EN to round half up instead of truncating.
module fixed_mac_pipe
  import fixed_mac_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 8,
  parameter int ACC_WIDTH = 56
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic                 acc_mode,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic                 ovf_sticky,
  input  logic                 sticky_clr
);

  localparam int PW = 2 * WIDTH - FRAC;

`ifdef FIXED_MAC_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif

  logic stall;

  logic                     s1_valid_q, s1_valid_d;
  logic signed [WIDTH-1:0]  s1_a_q, s1_a_d;
  logic signed [WIDTH-1:0]  s1_b_q, s1_b_d;
  mode_e                    s1_mode_q, s1_mode_d;
  logic                     s1_last_q, s1_last_d;

  logic                     s2_valid_q, s2_valid_d;
  logic signed [PW-1:0]     s2_prod_q, s2_prod_d;
  mode_e                    s2_mode_q, s2_mode_d;
  logic                     s2_last_q, s2_last_d;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        pend_q, pend_d;
  logic                        out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]        out_data_q, out_data_d;
  logic                        out_ovf_q, out_ovf_d;
  logic                        sticky_q, sticky_d;

  logic signed [2*WIDTH-1:0]   full;
  logic signed [ACC_WIDTH-1:0] add_acc;
  logic signed [ACC_WIDTH-1:0] add_res;
  logic                        add_sat;

  assign stall      = out_valid_q && !out_ready;
  assign in_ready   = !stall;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = sticky_q;

  // S1 capture and S2 product/shift; both hold while stalled.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_mode_d  = s2_mode_q;
    s2_last_d  = s2_last_q;
    full       = s1_a_q * s1_b_q;
    if (!stall) begin
      s1_valid_d = in_valid;
      s1_a_d     = a_in;
      s1_b_d     = b_in;
      s1_mode_d  = mode_e'(acc_mode);
      s1_last_d  = in_last;
      s2_valid_d = s1_valid_q;
      s2_prod_d  = PW'(shift_round(XW'(full), FRAC, RND));
      s2_mode_d  = s1_mode_q;
      s2_last_d  = s1_last_q;
    end
  end

  assign add_acc = (s2_mode_q == MODE_ACC) ? acc_q : '0;

  fixed_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .PW        (PW)
  ) u_sat_add (
    .acc  (add_acc),
    .prod (s2_prod_q),
    .res  (add_res),
    .sat  (add_sat)
  );

  // S3: emit products, update accumulator, track overflow flags.
  always_comb begin
    acc_d       = acc_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    sticky_d    = sticky_q;
    if (sticky_clr) sticky_d = 1'b0;
    if (!stall) begin
      out_valid_d = 1'b0;
      if (s2_valid_q) begin
        if (add_sat) sticky_d = 1'b1;
        unique case (1'b1)
          (s2_mode_q == MODE_MUL): begin
            out_valid_d = 1'b1;
            out_data_d  = add_res;
            out_ovf_d   = add_sat;
          end
          s2_last_q: begin
            out_valid_d = 1'b1;
            out_data_d  = add_res;
            out_ovf_d   = pend_q | add_sat;
            acc_d       = '0;
            pend_d      = 1'b0;
          end
          default: begin
            acc_d  = add_res;
            pend_d = pend_q | add_sat;
          end
        endcase
      end
    end
  end

  // State registers for all stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= MODE_MUL;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_mode_q   <= MODE_MUL;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_mode_q   <= s2_mode_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      sticky_q    <= sticky_d;
    end
  end

endmodule
